// File: rtl/miner_pkg.sv
// Shared constants for the miner's host-link transmit path:
// field widths, frame marker, frame length and FSM state encoding.
package miner_pkg;

  localparam int         NONCE_W     = 32;
  localparam int         HASH_W      = 256;
  localparam logic [7:0] SYNC_BYTE   = 8'hA5;
  localparam int         FRAME_BYTES = 2 + (NONCE_W + HASH_W) / 8;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] SYNC    = 2'd1;
  localparam logic [1:0] PAYLOAD = 2'd2;
  localparam logic [1:0] CSUM    = 2'd3;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/share_slot.sv
// One-entry holding register for a share that arrives while a frame is in flight.
// A capture into a full slot is refused and flagged via o_drop.
module share_slot #(
  parameter int W = miner_pkg::NONCE_W + miner_pkg::HASH_W
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         i_capture,
  input  logic [W-1:0] i_data,
  input  logic         i_consume,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_drop
);

  logic         r_valid;
  logic [W-1:0] r_data;
  logic         w_store;

  assign w_store = i_capture && !r_valid;
  assign o_drop  = i_capture && r_valid;
  assign o_valid = r_valid;
  assign o_data  = r_data;

  // Capture is evaluated before consume, so a full slot drops the newcomer
  // even in the cycle it is being emptied.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_store) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (i_consume) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/share_reporter.sv
// Host-link transmitter: frames a winning nonce and hash as SYNC, payload bytes
// (MSB first) and an XOR checksum over a valid/ready byte stream.
module share_reporter #(
  parameter logic [7:0] SYNC_BYTE = miner_pkg::SYNC_BYTE,
  parameter int         NONCE_W   = miner_pkg::NONCE_W,
  parameter int         HASH_W    = miner_pkg::HASH_W
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              hash_success,
  input  logic [NONCE_W-1:0] nonce,
  input  logic [HASH_W-1:0]  satisfactory_hash,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy,
  output logic [7:0]        drop_count
);
  import miner_pkg::*;

  localparam int               PAY_W     = NONCE_W + HASH_W;
  localparam int               PAY_BYTES = PAY_W / 8;
  localparam int               CNT_W     = $clog2(PAY_BYTES);
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(PAY_BYTES - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  logic [1:0]       r_state;
  logic [PAY_W-1:0] r_shift;
  logic [7:0]       r_csum;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_drop_count;

  logic             w_xfer;
  logic             w_csum_done;
  logic             w_capture;
  logic             w_slot_valid;
  logic [PAY_W-1:0] w_slot_data;
  logic             w_slot_drop;
  logic [7:0]       w_top_byte;
  logic [PAY_W-1:0] w_new_share;

  assign w_xfer      = tx_valid && tx_ready;
  assign w_csum_done = (r_state == CSUM) && w_xfer;
  assign w_top_byte  = r_shift[PAY_W-1 -: 8];
  assign w_new_share = {nonce, satisfactory_hash};

  // A share arriving on the final checksum transfer with the slot empty is
  // loaded straight into the shift register instead of going through the slot.
  assign w_capture = hash_success && (r_state != IDLE) &&
                     !(w_csum_done && !w_slot_valid);

  share_slot #(.W(PAY_W)) u_slot (
    .clock     (clock),
    .resetn    (resetn),
    .i_capture (w_capture),
    .i_data    (w_new_share),
    .i_consume (w_csum_done && w_slot_valid),
    .o_valid   (w_slot_valid),
    .o_data    (w_slot_data),
    .o_drop    (w_slot_drop)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_csum  <= 8'h00;
      r_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (hash_success) begin
            r_shift <= w_new_share;
            r_csum  <= 8'h00;
            r_state <= SYNC;
          end
        end
        SYNC: begin
          if (w_xfer) begin
            r_count <= '0;
            r_state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (w_xfer) begin
            r_shift <= {r_shift[PAY_W-9:0], 8'h00};
            r_csum  <= r_csum ^ w_top_byte;
            r_count <= r_count + ONE;
            if (r_count == LAST_IDX) r_state <= CSUM;
          end
        end
        CSUM: begin
          if (w_xfer) begin
            r_csum <= 8'h00;
            if (w_slot_valid) begin
              r_shift <= w_slot_data;
              r_state <= SYNC;
            end else if (hash_success) begin
              r_shift <= w_new_share;
              r_state <= SYNC;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)          r_drop_count <= 8'h00;
    else if (w_slot_drop) r_drop_count <= sat_inc8(r_drop_count);
  end

  always_comb begin
    tx_data = 8'h00;
    case (r_state)
      SYNC:    tx_data = SYNC_BYTE;
      PAYLOAD: tx_data = w_top_byte;
      CSUM:    tx_data = r_csum;
      default: tx_data = 8'h00;
    endcase
  end

  assign tx_valid   = (r_state != IDLE);
  assign busy       = tx_valid || w_slot_valid;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_share_reporter.sv
// Randomised scoreboard bench for share_reporter: the driver predicts whole
// frames and drops from share occupancy; a negedge monitor checks every byte.
module tb_share_reporter;

  logic         clock = 1'b0;
  logic         resetn;
  logic         hash_success;
  logic [31:0]  nonce;
  logic [255:0] satisfactory_hash;
  logic [7:0]   tx_data;
  logic         tx_valid;
  logic         tx_ready;
  logic         busy;
  logic [7:0]   drop_count;

  always #5 clock = ~clock;

  share_reporter dut (
    .clock             (clock),
    .resetn            (resetn),
    .hash_success      (hash_success),
    .nonce             (nonce),
    .satisfactory_hash (satisfactory_hash),
    .tx_data           (tx_data),
    .tx_valid          (tx_valid),
    .tx_ready          (tx_ready),
    .busy              (busy),
    .drop_count        (drop_count)
  );

  int         nChecks = 0;
  int         nPass   = 0;
  logic [7:0] expQ[$];
  int         accepted  = 0;
  int         completed = 0;
  int         drops     = 0;
  int         frameIdx  = 0;
  logic       prevStall = 1'b0;
  logic [8:0] prevOut   = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    nChecks++;
    if (actual === expected) nPass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Reference frame: SYNC, 36 payload bytes MSB first, XOR of the payload bytes.
  task automatic pushFrame(input logic [31:0] n, input logic [255:0] h);
    logic [287:0] payload;
    logic [7:0]   cs;
    logic [7:0]   b;
    payload = {n, h};
    cs = 8'h00;
    expQ.push_back(8'hA5);
    for (int i = 0; i < 36; i++) begin
      b = 8'((payload >> (8 * (35 - i))) & 288'hFF);
      cs = cs ^ b;
      expQ.push_back(b);
    end
    expQ.push_back(cs);
  endtask

  // One clock of stimulus; a share is accepted unless two are already outstanding.
  task automatic applyStimulus(input logic pulse, input logic [31:0] n,
                               input logic [255:0] h, input logic rdy);
    @(posedge clock);
    #1;
    hash_success      = pulse;
    nonce             = n;
    satisfactory_hash = h;
    tx_ready          = rdy;
    if (pulse && resetn) begin
      if (accepted - completed < 2) begin
        pushFrame(n, h);
        accepted++;
      end else begin
        drops++;
      end
    end
  endtask

  task automatic waitIdle(input int maxCycles, input logic randomReady,
                          output int validCycles);
    logic rdy;
    validCycles = 0;
    for (int c = 0; c < maxCycles; c++) begin
      if (expQ.size() == 0 && accepted == completed && !tx_valid) break;
      rdy = randomReady ? ($urandom_range(0, 3) != 0) : 1'b1;
      applyStimulus(1'b0, 32'h0, 256'h0, rdy);
      if (tx_valid) validCycles++;
    end
    checkOutput("drain_queue", 64'(expQ.size()), 0);
    checkOutput("idle_valid", tx_valid, 0);
    checkOutput("idle_busy", busy, 0);
  endtask

  function automatic logic [7:0] expDrops();
    return (drops > 255) ? 8'hFF : 8'(drops);
  endfunction

  task automatic flushModel();
    expQ.delete();
    accepted  = 0;
    completed = 0;
    drops     = 0;
    frameIdx  = 0;
  endtask

  always @(negedge clock) begin
    logic [7:0] exp;
    if (resetn) begin
      if (prevStall) checkOutput("stall_hold", {tx_valid, tx_data}, prevOut);
      if (tx_valid && tx_ready) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_byte", {1'b1, tx_data}, 0);
        end else begin
          exp = expQ.pop_front();
          checkOutput($sformatf("frame_byte%0d", frameIdx), tx_data, exp);
        end
        frameIdx++;
        if (frameIdx == 38) begin
          frameIdx = 0;
          completed++;
        end
      end
      prevStall = tx_valid && !tx_ready;
      prevOut   = {tx_valid, tx_data};
    end else begin
      prevStall = 1'b0;
    end
  end

  initial begin
    int v;
    int vw;
    logic hit;
    resetn = 1'b0;
    hash_success = 1'b0;
    nonce = '0;
    satisfactory_hash = '0;
    tx_ready = 1'b0;

    // Reset state, with a pulse that must be ignored while held in reset.
    applyStimulus(1'b1, 32'hDEADBEEF, 256'h1, 1'b1);
    applyStimulus(1'b0, 32'h0, 256'h0, 1'b1);
    checkOutput("rst_valid", tx_valid, 0);
    checkOutput("rst_data", tx_data, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_drop", drop_count, 0);
    resetn = 1'b1;
    applyStimulus(1'b0, 32'h0, 256'h0, 1'b1);
    checkOutput("post_rst_valid", tx_valid, 0);

    $display("[TB] zero share");
    applyStimulus(1'b1, 32'h0, 256'h0, 1'b1);
    checkOutput("pre_latency_valid", tx_valid, 0);
    applyStimulus(1'b0, 32'h0, 256'h0, 1'b1);
    checkOutput("latency_valid", tx_valid, 1);
    checkOutput("latency_sync", tx_data, 8'hA5);
    waitIdle(100, 1'b0, v);

    $display("[TB] checksum");
    applyStimulus(1'b1, 32'h01020304, 256'h0, 1'b1);
    waitIdle(100, 1'b0, v);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 32'h42a14695,
      256'h00000000000000001e8d6829a8a21adc5d38d0a473b144b6765798e61f98bd1d, 1'b0);
    waitIdle(400, 1'b1, v);

    $display("[TB] pending and drop");
    applyStimulus(1'b1, $urandom, {8{$urandom}}, 1'b1);
    v = 0;
    for (int i = 1; i <= 6; i++) begin
      applyStimulus(i == 4 || i == 5, $urandom, {8{$urandom}}, 1'b1);
      if (tx_valid) v++;
    end
    waitIdle(200, 1'b0, vw);
    checkOutput("back_to_back_cycles", 64'(v + vw), 76);
    checkOutput("drop_one", drop_count, expDrops());

    $display("[TB] pulse on checksum transfer");
    applyStimulus(1'b1, $urandom, {8{$urandom}}, 1'b1);
    hit = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (frameIdx == 36) begin hit = 1'b1; break; end
      applyStimulus(1'b0, 32'h0, 256'h0, 1'b1);
    end
    checkOutput("edge_reached", hit, 1);
    applyStimulus(1'b1, $urandom, {8{$urandom}}, 1'b1);
    checkOutput("edge_busy_csum", busy, 1);
    applyStimulus(1'b0, 32'h0, 256'h0, 1'b1);
    checkOutput("edge_busy_next", busy, 1);
    checkOutput("edge_valid_next", tx_valid, 1);
    checkOutput("edge_sync_next", tx_data, 8'hA5);
    waitIdle(100, 1'b0, v);

    $display("[TB] random traffic");
    for (int c = 0; c < 400; c++)
      applyStimulus($urandom_range(0, 11) == 0, $urandom, {8{$urandom}},
                    $urandom_range(0, 3) != 0);
    waitIdle(400, 1'b1, v);
    checkOutput("random_drops", drop_count, expDrops());

    $display("[TB] drop saturation");
    for (int c = 0; c < 400; c++)
      applyStimulus(1'b1, $urandom, {8{$urandom}}, 1'b1);
    waitIdle(200, 1'b0, v);
    checkOutput("drop_saturate", drop_count, 8'hFF);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, $urandom, {8{$urandom}}, 1'b1);
    hit = 1'b0;
    for (int c = 0; c < 60; c++) begin
      if (frameIdx == 10) begin hit = 1'b1; break; end
      applyStimulus(1'b0, 32'h0, 256'h0, 1'b1);
    end
    checkOutput("mid_frame_reached", hit, 1);
    @(posedge clock);
    #1;
    resetn = 1'b0;
    #1;
    checkOutput("midrst_valid", tx_valid, 0);
    checkOutput("midrst_busy", busy, 0);
    checkOutput("midrst_drop", drop_count, 0);
    flushModel();
    applyStimulus(1'b0, 32'h0, 256'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 256'h0, 1'b1);
    resetn = 1'b1;
    applyStimulus(1'b1, $urandom, {8{$urandom}}, 1'b1);
    applyStimulus(1'b0, 32'h0, 256'h0, 1'b1);
    checkOutput("fresh_sync", tx_data, 8'hA5);
    waitIdle(100, 1'b0, v);
    checkOutput("fresh_frames", 64'(completed), 1);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
